ahbl_lmmi_posted_bridge: RTL and testbench

Second-generation AHB-Lite subordinate to LMMI manager bridge, parametrised in data width, offset width and offset LSB position. Writes are posted through a WR_FIFO_DEPTH-entry {offset, data} FIFO so the AHB bus is released before LMMI completes them. Reads are ordered behind all posted writes. A read timeout produces a proper two-cycle AHB ERROR response. It sits between the fabric AHB-Lite interconnect and LMMI-based hard IP or register banks.

---
 rtl/ahbl_lmmi_posted_bridge_if.sv | 43 ++++
 rtl/ahbl_lmmi_posted_bridge.sv | 198 +++++++++++++++++++
 tb/tb_ahbl_lmmi_posted_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_lmmi_posted_bridge_if.sv
// Bus bundle between an AHB-Lite manager / LMMI subordinate environment and the
// posted-write bridge. The slave modport is the bridge's view of the signals.
interface ahbl_lmmi_posted_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 15
);
  logic [31:0]           ahbl_haddr_i;
  logic [DATA_WIDTH-1:0] ahbl_hwdata_i;
  logic                  ahbl_hsel_i;
  logic [1:0]            ahbl_htrans_i;
  logic                  ahbl_hwrite_i;
  logic                  ahbl_hready_i;
  logic [2:0]            ahbl_hsize_i;
  logic [2:0]            ahbl_hburst_i;
  logic [3:0]            ahbl_hprot_i;
  logic                  ahbl_hmastlock_i;
  logic [DATA_WIDTH-1:0] ahbl_hrdata_o;
  logic                  ahbl_hreadyout_o;
  logic                  ahbl_hresp_o;
  logic                  lmmi_request_o;
  logic                  lmmi_wr_rdn_o;
  logic [ADDR_WIDTH-1:0] lmmi_offset_o;
  logic [DATA_WIDTH-1:0] lmmi_wdata_o;
  logic                  lmmi_ready_i;
  logic [DATA_WIDTH-1:0] lmmi_rdata_i;
  logic                  lmmi_rdata_valid_i;

  modport slave (
    input  ahbl_haddr_i, ahbl_hwdata_i, ahbl_hsel_i, ahbl_htrans_i, ahbl_hwrite_i,
    input  ahbl_hready_i, ahbl_hsize_i, ahbl_hburst_i, ahbl_hprot_i, ahbl_hmastlock_i,
    output ahbl_hrdata_o, ahbl_hreadyout_o, ahbl_hresp_o,
    output lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o,
    input  lmmi_ready_i, lmmi_rdata_i, lmmi_rdata_valid_i
  );

  modport master (
    output ahbl_haddr_i, ahbl_hwdata_i, ahbl_hsel_i, ahbl_htrans_i, ahbl_hwrite_i,
    output ahbl_hready_i, ahbl_hsize_i, ahbl_hburst_i, ahbl_hprot_i, ahbl_hmastlock_i,
    input  ahbl_hrdata_o, ahbl_hreadyout_o, ahbl_hresp_o,
    input  lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o,
    output lmmi_ready_i, lmmi_rdata_i, lmmi_rdata_valid_i
  );
endinterface

// File: rtl/ahbl_lmmi_posted_bridge.sv
// AHB-Lite subordinate to LMMI manager bridge. Writes are posted through a small
// {offset, data} FIFO; reads wait for the FIFO to drain and time out into a
// two-cycle AHB ERROR response.
module ahbl_lmmi_posted_bridge #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 15,
  parameter int unsigned ADDR_LSB      = 2,
  parameter int unsigned WR_FIFO_DEPTH = 4,
  parameter int unsigned RD_TIMEOUT    = 255,
  parameter int unsigned EN_TIMEOUT_RD = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  ahbl_lmmi_posted_bridge_if.slave          bus,
  output logic [$clog2(WR_FIFO_DEPTH):0]    wr_fifo_level_o
);

  localparam int unsigned PTR_W = $clog2(WR_FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(WR_FIFO_DEPTH) + 1;
  localparam int unsigned TMO_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_RD_DRAIN, S_RD_REQ, S_RD_WAIT, S_ERR1, S_ERR2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] data;
  } wr_entry_t;

  state_t                r_state, w_state_nxt;
  wr_entry_t             r_fifo [WR_FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr, r_rptr, w_rptr_nxt;
  logic [LVL_W-1:0]      r_level, w_level_popped, w_level_nxt;
  logic [TMO_W-1:0]      r_tmo_cnt, w_tmo_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_acc_offset, w_acc_offset_nxt;

  logic                  r_hreadyout, w_hreadyout_nxt;
  logic                  r_hresp, w_hresp_nxt;
  logic [DATA_WIDTH-1:0] r_hrdata, w_hrdata_nxt;
  logic                  r_request, w_request_nxt;
  logic                  r_wr_rdn, w_wr_rdn_nxt;
  logic [ADDR_WIDTH-1:0] r_offset, w_offset_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;

  logic                  w_acc, w_push, w_pop, w_tmo;
  logic [ADDR_WIDTH-1:0] w_haddr_offset;
  wr_entry_t             w_push_entry, w_head_nxt;
  logic                  w_unused;

  assign w_acc          = bus.ahbl_hsel_i & bus.ahbl_htrans_i[1] & bus.ahbl_hready_i & r_hreadyout;
  assign w_haddr_offset = bus.ahbl_haddr_i[ADDR_LSB +: ADDR_WIDTH];
  assign w_push         = (r_state == S_WDATA) & r_hreadyout;
  assign w_pop          = r_request & r_wr_rdn & bus.lmmi_ready_i;
  assign w_tmo          = (EN_TIMEOUT_RD != 0) && (r_tmo_cnt == TMO_W'(RD_TIMEOUT));
  assign w_push_entry   = '{offset: r_acc_offset, data: bus.ahbl_hwdata_i};
  assign w_level_popped = r_level - LVL_W'(w_pop);
  assign w_level_nxt    = w_level_popped + LVL_W'(w_push);
  assign w_rptr_nxt     = r_rptr + PTR_W'(w_pop);
  // Entry presented to LMMI next cycle; a push into an empty FIFO bypasses the array
  assign w_head_nxt     = (w_level_popped == '0) ? w_push_entry : r_fifo[w_rptr_nxt];
  assign w_unused       = ^{bus.ahbl_haddr_i, bus.ahbl_hsize_i, bus.ahbl_hburst_i,
                            bus.ahbl_hprot_i, bus.ahbl_hmastlock_i};

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_hreadyout_nxt  = r_hreadyout;
    w_hresp_nxt      = 1'b0;
    w_hrdata_nxt     = r_hrdata;
    w_acc_offset_nxt = r_acc_offset;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_request_nxt    = (w_level_nxt != '0);
    w_wr_rdn_nxt     = r_wr_rdn;
    w_offset_nxt     = r_offset;
    w_wdata_nxt      = r_wdata;
    if (w_level_nxt != '0) begin
      w_wr_rdn_nxt = 1'b1;
      w_offset_nxt = w_head_nxt.offset;
      w_wdata_nxt  = w_head_nxt.data;
    end
    case (r_state)
      S_IDLE, S_ERR2, S_WDATA: begin
        if ((r_state == S_WDATA) && !r_hreadyout) begin
          // stalled write data phase: release once a pop frees a slot
          w_hreadyout_nxt = (w_level_nxt < LVL_W'(WR_FIFO_DEPTH));
        end else if (w_acc && bus.ahbl_hwrite_i) begin
          w_state_nxt      = S_WDATA;
          w_acc_offset_nxt = w_haddr_offset;
          w_hreadyout_nxt  = (w_level_nxt < LVL_W'(WR_FIFO_DEPTH));
        end else if (w_acc) begin
          w_acc_offset_nxt = w_haddr_offset;
          w_tmo_cnt_nxt    = '0;
          w_hreadyout_nxt  = 1'b0;
          if (w_level_nxt == '0) begin
            w_state_nxt   = S_RD_REQ;
            w_request_nxt = 1'b1;
            w_wr_rdn_nxt  = 1'b0;
            w_offset_nxt  = w_haddr_offset;
          end else begin
            w_state_nxt = S_RD_DRAIN;
          end
        end else begin
          w_state_nxt     = S_IDLE;
          w_hreadyout_nxt = 1'b1;
        end
      end
      S_RD_DRAIN: begin
        if (w_level_nxt == '0) begin
          w_state_nxt   = S_RD_REQ;
          w_request_nxt = 1'b1;
          w_wr_rdn_nxt  = 1'b0;
          w_offset_nxt  = r_acc_offset;
        end
      end
      S_RD_REQ, S_RD_WAIT: begin
        w_request_nxt = (r_state == S_RD_REQ);
        w_wr_rdn_nxt  = 1'b0;
        if (r_tmo_cnt != '1) begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
        if (bus.lmmi_rdata_valid_i) begin
          w_state_nxt     = S_IDLE;
          w_request_nxt   = 1'b0;
          w_hrdata_nxt    = bus.lmmi_rdata_i;
          w_hreadyout_nxt = 1'b1;
        end else if (w_tmo) begin
          w_state_nxt   = S_ERR1;
          w_request_nxt = 1'b0;
          w_hrdata_nxt  = '0;
          w_hresp_nxt   = 1'b1;
        end else if ((r_state == S_RD_REQ) && bus.lmmi_ready_i) begin
          w_state_nxt   = S_RD_WAIT;
          w_request_nxt = 1'b0;
        end
      end
      S_ERR1: begin
        w_state_nxt     = S_ERR2;
        w_hreadyout_nxt = 1'b1;
        w_hresp_nxt     = 1'b1;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_hreadyout_nxt = 1'b1;
      end
    endcase
  end

  // State, pointer and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_tmo_cnt    <= '0;
      r_acc_offset <= '0;
      r_hreadyout  <= 1'b1;
      r_hresp      <= 1'b0;
      r_hrdata     <= '0;
      r_request    <= 1'b0;
      r_wr_rdn     <= 1'b0;
      r_offset     <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wptr       <= r_wptr + PTR_W'(w_push);
      r_rptr       <= w_rptr_nxt;
      r_level      <= w_level_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_acc_offset <= w_acc_offset_nxt;
      r_hreadyout  <= w_hreadyout_nxt;
      r_hresp      <= w_hresp_nxt;
      r_hrdata     <= w_hrdata_nxt;
      r_request    <= w_request_nxt;
      r_wr_rdn     <= w_wr_rdn_nxt;
      r_offset     <= w_offset_nxt;
      r_wdata      <= w_wdata_nxt;
    end
  end

  // Posted-write storage; emptiness is tracked by the reset pointers
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_push_entry;
    end
  end

  assign bus.ahbl_hrdata_o    = r_hrdata;
  assign bus.ahbl_hreadyout_o = r_hreadyout;
  assign bus.ahbl_hresp_o     = r_hresp;
  assign bus.lmmi_request_o   = r_request;
  assign bus.lmmi_wr_rdn_o    = r_wr_rdn;
  assign bus.lmmi_offset_o    = r_offset;
  assign bus.lmmi_wdata_o     = r_wdata;
  assign wr_fifo_level_o      = r_level;

endmodule

// File: tb/tb_ahbl_lmmi_posted_bridge.sv
// Directed bench for the posted-write AHB-Lite to LMMI bridge (DEPTH=4, RD_TIMEOUT=15).
module tb_ahbl_lmmi_posted_bridge;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 15;

  logic       clk_i;
  logic       rst_n_i;
  logic [2:0] level;
  int         n_chk;
  int         n_err;
  logic       seen_req;

  ahbl_lmmi_posted_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  assign bus.ahbl_hready_i = bus.ahbl_hreadyout_o;

  ahbl_lmmi_posted_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_LSB(2),
    .WR_FIFO_DEPTH(4), .RD_TIMEOUT(15), .EN_TIMEOUT_RD(1)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .bus             (bus),
    .wr_fifo_level_o (level)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic wr);
    bus.ahbl_hsel_i   = 1'b1;
    bus.ahbl_htrans_i = 2'b10;
    bus.ahbl_haddr_i  = a;
    bus.ahbl_hwrite_i = wr;
  endtask

  task automatic bus_idle();
    bus.ahbl_hsel_i   = 1'b0;
    bus.ahbl_htrans_i = 2'b00;
    bus.ahbl_hwrite_i = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n_i = 1'b0;
    bus_idle();
    bus.ahbl_haddr_i       = '0;
    bus.ahbl_hwdata_i      = '0;
    bus.ahbl_hsize_i       = 3'b010;
    bus.ahbl_hburst_i      = 3'b000;
    bus.ahbl_hprot_i       = 4'b0011;
    bus.ahbl_hmastlock_i   = 1'b0;
    bus.lmmi_ready_i       = 1'b0;
    bus.lmmi_rdata_i       = '0;
    bus.lmmi_rdata_valid_i = 1'b0;
    step();
    step();
    chk("rst_hreadyout", bus.ahbl_hreadyout_o, 1);
    chk("rst_hresp", bus.ahbl_hresp_o, 0);
    chk("rst_hrdata", bus.ahbl_hrdata_o, 0);
    chk("rst_request", bus.lmmi_request_o, 0);
    chk("rst_wr_rdn", bus.lmmi_wr_rdn_o, 0);
    chk("rst_offset", bus.lmmi_offset_o, 0);
    chk("rst_wdata", bus.lmmi_wdata_o, 0);
    chk("rst_level", level, 0);
    rst_n_i = 1'b1;
    step();

    // single write, LMMI always ready
    bus.lmmi_ready_i = 1'b1;
    addr_ph(32'h0000_0010, 1'b1);
    step();
    chk("w1_dp_hready", bus.ahbl_hreadyout_o, 1);
    bus.ahbl_hwdata_i = 32'h1234_5678;
    bus_idle();
    step();
    chk("w1_request", bus.lmmi_request_o, 1);
    chk("w1_wr_rdn", bus.lmmi_wr_rdn_o, 1);
    chk("w1_offset", bus.lmmi_offset_o, 15'h4);
    chk("w1_wdata", bus.lmmi_wdata_o, 32'h1234_5678);
    chk("w1_level1", level, 1);
    step();
    chk("w1_level0", level, 0);
    chk("w1_req_drop", bus.lmmi_request_o, 0);

    // six back-to-back writes with LMMI stalled
    bus.lmmi_ready_i = 1'b0;
    addr_ph(32'h0000_0100, 1'b1);
    step();
    chk("w6_dp0_hready", bus.ahbl_hreadyout_o, 1);
    for (int k = 1; k <= 4; k++) begin
      bus.ahbl_hwdata_i = 32'hD000_0000 + 32'(k - 1);
      addr_ph(32'h0000_0100 + 32'(4 * k), 1'b1);
      step();
      chk("w6_hready", bus.ahbl_hreadyout_o, (k < 4) ? 1 : 0);
      chk("w6_level", level, 64'(k));
    end
    chk("w6_head_offset", bus.lmmi_offset_o, 15'h40);
    bus.ahbl_hwdata_i = 32'hD000_0004;
    addr_ph(32'h0000_0114, 1'b1);
    step();
    chk("w6_stall_hready", bus.ahbl_hreadyout_o, 0);
    chk("w6_stall_level", level, 4);
    bus.lmmi_ready_i = 1'b1;
    step();
    chk("w6_release_hready", bus.ahbl_hreadyout_o, 1);
    chk("w6_release_level", level, 3);
    chk("w6_off1", bus.lmmi_offset_o, 15'h41);
    chk("w6_dat1", bus.lmmi_wdata_o, 32'hD000_0001);
    step();
    chk("w6_w5_hready", bus.ahbl_hreadyout_o, 1);
    chk("w6_off2", bus.lmmi_offset_o, 15'h42);
    chk("w6_level_e7", level, 3);
    bus.ahbl_hwdata_i = 32'hD000_0005;
    bus_idle();
    for (int k = 3; k <= 5; k++) begin
      step();
      chk("w6_drain_off", bus.lmmi_offset_o, 64'(15'h40 + 15'(k)));
      chk("w6_drain_dat", bus.lmmi_wdata_o, 64'(32'hD000_0000 + 32'(k)));
      chk("w6_drain_level", level, 64'(6 - k));
    end
    step();
    chk("w6_empty_level", level, 0);
    chk("w6_empty_req", bus.lmmi_request_o, 0);

    // three posted writes then a read ordered behind them
    addr_ph(32'h0000_0080, 1'b1);
    step();
    bus.ahbl_hwdata_i = 32'h0000_0A00;
    addr_ph(32'h0000_0084, 1'b1);
    step();
    chk("wr3_off0", bus.lmmi_offset_o, 15'h20);
    bus.ahbl_hwdata_i = 32'h0000_0A01;
    addr_ph(32'h0000_0088, 1'b1);
    step();
    chk("wr3_off1", bus.lmmi_offset_o, 15'h21);
    bus.ahbl_hwdata_i = 32'h0000_0A02;
    addr_ph(32'h0000_0020, 1'b0);
    step();
    chk("wr3_off2", bus.lmmi_offset_o, 15'h22);
    chk("wr3_still_write", bus.lmmi_wr_rdn_o, 1);
    chk("rd_hready_low", bus.ahbl_hreadyout_o, 0);
    bus_idle();
    step();
    chk("rd_request", bus.lmmi_request_o, 1);
    chk("rd_wr_rdn", bus.lmmi_wr_rdn_o, 0);
    chk("rd_offset", bus.lmmi_offset_o, 15'h8);
    chk("rd_level", level, 0);
    step();
    chk("rd_req_drop", bus.lmmi_request_o, 0);
    chk("rd_wait_hready", bus.ahbl_hreadyout_o, 0);
    bus.lmmi_rdata_valid_i = 1'b1;
    bus.lmmi_rdata_i = 32'hA5A5_0001;
    step();
    bus.lmmi_rdata_valid_i = 1'b0;
    chk("rd_hrdata", bus.ahbl_hrdata_o, 32'hA5A5_0001);
    chk("rd_hready", bus.ahbl_hreadyout_o, 1);
    chk("rd_hresp", bus.ahbl_hresp_o, 0);

    // read timeout with no ready and no valid
    bus.lmmi_ready_i = 1'b0;
    addr_ph(32'h0000_0044, 1'b0);
    step();
    bus_idle();
    chk("to_offset", bus.lmmi_offset_o, 15'h11);
    for (int i = 1; i <= 15; i++) step();
    chk("to_pre_hresp", bus.ahbl_hresp_o, 0);
    chk("to_pre_req", bus.lmmi_request_o, 1);
    step();
    chk("to_err1_hready", bus.ahbl_hreadyout_o, 0);
    chk("to_err1_hresp", bus.ahbl_hresp_o, 1);
    chk("to_err1_hrdata", bus.ahbl_hrdata_o, 0);
    chk("to_err1_req", bus.lmmi_request_o, 0);
    bus.lmmi_rdata_valid_i = 1'b1;
    bus.lmmi_rdata_i = 32'hDEAD_BEEF;
    step();
    chk("to_err2_hready", bus.ahbl_hreadyout_o, 1);
    chk("to_err2_hresp", bus.ahbl_hresp_o, 1);
    step();
    chk("to_okay_hresp", bus.ahbl_hresp_o, 0);
    chk("to_late_valid", bus.ahbl_hrdata_o, 0);
    bus.lmmi_rdata_valid_i = 1'b0;

    // best-case read after the timeout: ready and valid together
    addr_ph(32'h0000_0044, 1'b0);
    step();
    bus_idle();
    bus.lmmi_ready_i = 1'b1;
    bus.lmmi_rdata_valid_i = 1'b1;
    bus.lmmi_rdata_i = 32'h0BAD_F00D;
    step();
    bus.lmmi_rdata_valid_i = 1'b0;
    bus.lmmi_ready_i = 1'b0;
    chk("fast_hrdata", bus.ahbl_hrdata_o, 32'h0BAD_F00D);
    chk("fast_hready", bus.ahbl_hreadyout_o, 1);
    chk("fast_hresp", bus.ahbl_hresp_o, 0);

    // valid coincides with the timeout match
    addr_ph(32'h0000_0048, 1'b0);
    step();
    bus_idle();
    for (int i = 1; i <= 15; i++) step();
    bus.lmmi_rdata_valid_i = 1'b1;
    bus.lmmi_rdata_i = 32'h600D_0015;
    step();
    bus.lmmi_rdata_valid_i = 1'b0;
    chk("race_hready", bus.ahbl_hreadyout_o, 1);
    chk("race_hresp", bus.ahbl_hresp_o, 0);
    chk("race_hrdata", bus.ahbl_hrdata_o, 32'h600D_0015);
    step();
    chk("race_hresp_after", bus.ahbl_hresp_o, 0);

    // reset with two writes queued and a read draining
    addr_ph(32'h0000_0200, 1'b1);
    step();
    bus.ahbl_hwdata_i = 32'h0000_0B00;
    addr_ph(32'h0000_0204, 1'b1);
    step();
    bus.ahbl_hwdata_i = 32'h0000_0B01;
    addr_ph(32'h0000_0000, 1'b0);
    step();
    bus_idle();
    chk("rstq_level", level, 2);
    chk("rstq_req", bus.lmmi_request_o, 1);
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    chk("rstq_req_drop", bus.lmmi_request_o, 0);
    chk("rstq_hready", bus.ahbl_hreadyout_o, 1);
    chk("rstq_level0", level, 0);
    bus.lmmi_ready_i = 1'b1;
    seen_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.lmmi_request_o !== 1'b0) seen_req = 1'b1;
    end
    chk("rstq_no_activity", seen_req, 0);

    // reset while waiting for read data
    addr_ph(32'h0000_000C, 1'b0);
    step();
    bus_idle();
    step();
    chk("rstw_in_wait", bus.ahbl_hreadyout_o, 0);
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    chk("rstw_hready", bus.ahbl_hreadyout_o, 1);
    chk("rstw_req", bus.lmmi_request_o, 0);
    bus.lmmi_rdata_valid_i = 1'b1;
    bus.lmmi_rdata_i = 32'hFFFF_0000;
    step();
    bus.lmmi_rdata_valid_i = 1'b0;
    chk("rstw_stray_valid", bus.ahbl_hrdata_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
